// File: rtl/vlc_pkg.sv
// vlc_pkg: shared default widths, field offsets and state encoding for the VLC bit packer
package vlc_pkg;
   localparam int DEF_CODE_W = 16;
   localparam int DEF_LEN_W = 5;
   localparam int DEF_OUT_W = 32;
   localparam int LEN_LSB = DEF_CODE_W;
   localparam int LEN_MSB = DEF_CODE_W + DEF_LEN_W - 1;
   localparam int ACC_W = DEF_OUT_W + DEF_CODE_W;
   typedef enum logic [1:0] {RUN, FLUSH, LAST} state_t;
endpackage

// File: rtl/vlc_field_split.sv
// vlc_field_split: extracts the length and code fields, clamps the length and masks unused code bits
module vlc_field_split
   import vlc_pkg::*;
#(
   parameter int CODE_W = DEF_CODE_W,
   parameter int LEN_W = DEF_LEN_W
) (
   input logic [CODE_W+LEN_W:0] word,
   output logic [LEN_W-1:0] len_raw,
   output logic [LEN_W-1:0] len_eff,
   output logic [CODE_W-1:0] code,
   output logic len_over
);
   logic unused_rsvd;
   assign unused_rsvd = word[CODE_W+LEN_W];
   assign len_raw = word[CODE_W+LEN_W-1:CODE_W];
   assign len_over = 32'(len_raw) > CODE_W;
   assign len_eff = len_over ? LEN_W'(CODE_W) : len_raw;
   assign code = word[CODE_W-1:0] & ~({CODE_W{1'b1}} << len_eff);
endmodule

// File: rtl/vlc_bit_packer.sv
// vlc_bit_packer: packs length-tagged VLC codes MSB-first into fixed-width words with flush support
module vlc_bit_packer
   import vlc_pkg::*;
#(
   parameter int CODE_W = DEF_CODE_W,
   parameter int LEN_W = DEF_LEN_W,
   parameter int OUT_W = DEF_OUT_W,
   parameter int CNT_W = 32
) (
   input logic clk,
   input logic rstN,
   input logic [CODE_W+LEN_W:0] vlc_code,
   input logic vlc_valid,
   output logic vlc_ready,
   input logic flush_req,
   output logic [OUT_W-1:0] out_data,
   output logic out_valid,
   input logic out_ready,
   output logic out_last,
   output logic [$clog2(OUT_W):0] out_nbits,
   output logic [LEN_W-1:0] code_length,
   output logic len_err,
   output logic flush_done,
   output logic [CNT_W-1:0] total_bits
);
   localparam int ACC_BITS = OUT_W + CODE_W;
   localparam int BC_W = $clog2(ACC_BITS + 1);
   localparam int NB_W = $clog2(OUT_W) + 1;
   localparam logic [BC_W-1:0] OUT_CNT = BC_W'(OUT_W);
   state_t state;
   logic [ACC_BITS-1:0] acc, acc_pop, acc_nxt;
   logic [BC_W-1:0] bit_cnt, cnt_pop, cnt_nxt;
   logic [LEN_W-1:0] len_raw, len_eff;
   logic [CODE_W-1:0] code;
   logic len_over, fire, out_free, pop, drained, part;
   vlc_field_split #(.CODE_W(CODE_W), .LEN_W(LEN_W)) u_split (
      .word(vlc_code),
      .len_raw(len_raw),
      .len_eff(len_eff),
      .code(code),
      .len_over(len_over)
   );
   assign fire = vlc_valid && vlc_ready;
   assign out_free = !out_valid || out_ready;
   assign pop = (bit_cnt >= OUT_CNT) && out_free;
   assign drained = (state == FLUSH) && (bit_cnt < OUT_CNT) && out_free;
   assign part = drained && (bit_cnt != '0);
   // Pop a full word first, then append the new code directly below the bits that remain
   always_comb begin
      cnt_pop = pop ? bit_cnt - OUT_CNT : bit_cnt;
      acc_pop = pop ? acc << OUT_W : acc;
      acc_nxt = part ? '0 : fire ? acc_pop | ((ACC_BITS'(code) << (ACC_BITS - int'(len_eff))) >> cnt_pop) : acc_pop;
      cnt_nxt = part ? '0 : fire ? cnt_pop + BC_W'(len_eff) : cnt_pop;
   end
   // Flush state machine, registered handshakes, output word register and statistics
   always_ff @(posedge clk) begin
      if (!rstN) begin
         state <= RUN;
         acc <= '0;
         bit_cnt <= '0;
         vlc_ready <= 1'b0;
         out_data <= '0;
         out_valid <= 1'b0;
         out_last <= 1'b0;
         out_nbits <= '0;
         code_length <= '0;
         len_err <= 1'b0;
         flush_done <= 1'b0;
         total_bits <= '0;
      end else begin
         acc <= acc_nxt;
         bit_cnt <= cnt_nxt;
         if (fire) begin
            code_length <= len_raw;
            total_bits <= total_bits + CNT_W'(len_eff);
            len_err <= len_err | len_over;
         end
         if (pop || part) begin
            out_data <= acc[ACC_BITS-1 -: OUT_W];
            out_nbits <= pop ? NB_W'(OUT_W) : NB_W'(bit_cnt);
            out_last <= part;
            out_valid <= 1'b1;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
         case (state)
            RUN: begin
               state <= flush_req ? FLUSH : RUN;
               vlc_ready <= !flush_req && (cnt_nxt <= OUT_CNT);
               flush_done <= 1'b0;
            end
            FLUSH: begin
               state <= part ? LAST : drained ? RUN : FLUSH;
               vlc_ready <= drained && !part;
               flush_done <= drained && !part;
            end
            default: begin
               state <= out_free ? RUN : LAST;
               vlc_ready <= out_free;
               flush_done <= out_free;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_vlc_bit_packer.sv
// tb_vlc_bit_packer: table-driven single-code flush vectors plus directed multi-cycle sequences
module tb_vlc_bit_packer;
   logic clk = 1'b0;
   logic rstN = 1'b0;
   logic [21:0] vlc_code = '0;
   logic vlc_valid = 1'b0;
   logic flush_req = 1'b0;
   logic out_ready = 1'b1;
   logic vlc_ready, out_valid, out_last, len_err, flush_done;
   logic [31:0] out_data, total_bits;
   logic [5:0] out_nbits;
   logic [4:0] code_length;
   int checks = 0;
   int errors = 0;
   typedef struct {
      logic [15:0] code;
      logic [4:0] len;
      logic [31:0] data;
      int nbits;
      logic err;
   } vec_t;
   vec_t vecs [7];

   vlc_bit_packer dut (
      .clk(clk),
      .rstN(rstN),
      .vlc_code(vlc_code),
      .vlc_valid(vlc_valid),
      .vlc_ready(vlc_ready),
      .flush_req(flush_req),
      .out_data(out_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_last(out_last),
      .out_nbits(out_nbits),
      .code_length(code_length),
      .len_err(len_err),
      .flush_done(flush_done),
      .total_bits(total_bits)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rstN = 1'b0;
      vlc_valid = 1'b0;
      flush_req = 1'b0;
      step();
      rstN = 1'b1;
   endtask

   task automatic send(input logic [15:0] c, input logic [4:0] l);
      int n = 0;
      vlc_code = {1'b1, l, c};
      vlc_valid = 1'b1;
      while (!vlc_ready && n < 50) begin
         step();
         n++;
      end
      chk("send_ready", vlc_ready, 1);
      step();
      vlc_valid = 1'b0;
   endtask

   task automatic flush_run(input string nm, input logic [31:0] ed, input int en);
      int n = 0;
      logic seen = 1'b0;
      logic [31:0] d = '0;
      int nb = 0;
      flush_req = 1'b1;
      step();
      flush_req = 1'b0;
      while (!flush_done && n < 40) begin
         if (out_valid && out_last) begin
            seen = 1'b1;
            d = out_data;
            nb = int'(out_nbits);
         end
         step();
         n++;
      end
      chk({nm, "_done"}, flush_done, 1);
      chk({nm, "_word"}, seen, en != 0);
      if (en != 0) begin
         chk({nm, "_data"}, d, ed);
         chk({nm, "_nbits"}, nb, en);
      end
      step();
      chk({nm, "_pulse"}, flush_done, 0);
   endtask

   initial begin
      vecs[0] = '{16'h0005, 5'd3, 32'hA000_0000, 3, 1'b0};
      vecs[1] = '{16'hFFFF, 5'd1, 32'h8000_0000, 1, 1'b0};
      vecs[2] = '{16'h8001, 5'd16, 32'h8001_0000, 16, 1'b0};
      vecs[3] = '{16'h00FF, 5'd20, 32'h00FF_0000, 16, 1'b1};
      vecs[4] = '{16'h1234, 5'd31, 32'h1234_0000, 16, 1'b1};
      vecs[5] = '{16'h0F0F, 5'd8, 32'h0F00_0000, 8, 1'b0};
      vecs[6] = '{16'hFFFF, 5'd0, 32'h0000_0000, 0, 1'b0};

      do_reset();
      chk("rst_out_valid", out_valid, 0);
      chk("rst_vlc_ready", vlc_ready, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_nbits", out_nbits, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_total", total_bits, 0);
      chk("rst_len_err", len_err, 0);
      chk("rst_code_len", code_length, 0);
      chk("rst_flush_done", flush_done, 0);

      for (int i = 0; i < 7; i++) begin
         do_reset();
         send(vecs[i].code, vecs[i].len);
         chk($sformatf("v%0d_code_len", i), code_length, vecs[i].len);
         chk($sformatf("v%0d_len_err", i), len_err, vecs[i].err);
         chk($sformatf("v%0d_total", i), total_bits, vecs[i].nbits);
         flush_run($sformatf("v%0d", i), vecs[i].data, vecs[i].nbits);
      end

      do_reset();
      send(16'hABCD, 5'd16);
      send(16'h1234, 5'd16);
      chk("t1_early", out_valid, 0);
      step();
      chk("t1_valid", out_valid, 1);
      chk("t1_data", out_data, 32'hABCD_1234);
      chk("t1_nbits", out_nbits, 32);
      chk("t1_last", out_last, 0);
      chk("t1_total", total_bits, 32);
      step();
      chk("t1_drop", out_valid, 0);

      do_reset();
      send(16'h0005, 5'd3);
      send(16'h0013, 5'd5);
      flush_req = 1'b1;
      step();
      flush_req = 1'b0;
      chk("t2_wait", out_valid, 0);
      step();
      chk("t2_valid", out_valid, 1);
      chk("t2_data", out_data, 32'hB300_0000);
      chk("t2_last", out_last, 1);
      chk("t2_nbits", out_nbits, 8);
      chk("t2_no_done", flush_done, 0);
      step();
      chk("t2_done", flush_done, 1);
      chk("t2_drop", out_valid, 0);
      step();
      chk("t2_pulse", flush_done, 0);
      chk("t2_ready", vlc_ready, 1);

      do_reset();
      out_ready = 1'b0;
      send(16'hAAAA, 5'd16);
      send(16'hBBBB, 5'd16);
      send(16'hCCCC, 5'd16);
      send(16'hDDDD, 5'd16);
      send(16'hEEEE, 5'd16);
      chk("t3_full", vlc_ready, 0);
      chk("t3_valid", out_valid, 1);
      chk("t3_data", out_data, 32'hAAAA_BBBB);
      repeat (3) step();
      chk("t3_hold_data", out_data, 32'hAAAA_BBBB);
      chk("t3_hold_valid", out_valid, 1);
      chk("t3_hold_ready", vlc_ready, 0);
      out_ready = 1'b1;
      step();
      chk("t3_second_valid", out_valid, 1);
      chk("t3_second_data", out_data, 32'hCCCC_DDDD);
      chk("t3_second_last", out_last, 0);
      step();
      chk("t3_drop", out_valid, 0);
      chk("t3_total", total_bits, 80);
      flush_run("t3_tail", 32'hEEEE_0000, 16);

      do_reset();
      send(16'h00FF, 5'd20);
      chk("t4_len_err", len_err, 1);
      chk("t4_code_len", code_length, 20);
      chk("t4_total", total_bits, 16);
      send(16'hFFFF, 5'd0);
      chk("t4_zero_len", code_length, 0);
      chk("t4_zero_total", total_bits, 16);
      chk("t4_sticky", len_err, 1);
      flush_run("t4", 32'h00FF_0000, 16);
      do_reset();
      chk("t4_err_clear", len_err, 0);

      do_reset();
      send(16'h1234, 5'd16);
      send(16'h0056, 5'd8);
      rstN = 1'b0;
      step();
      chk("t5_valid", out_valid, 0);
      chk("t5_ready", vlc_ready, 0);
      chk("t5_total", total_bits, 0);
      chk("t5_code_len", code_length, 0);
      chk("t5_data", out_data, 0);
      chk("t5_nbits", out_nbits, 0);
      rstN = 1'b1;
      flush_req = 1'b1;
      step();
      flush_req = 1'b0;
      chk("t5_wait_valid", out_valid, 0);
      chk("t5_wait_done", flush_done, 0);
      step();
      chk("t5_done", flush_done, 1);
      chk("t5_no_word", out_valid, 0);
      step();
      chk("t5_pulse", flush_done, 0);

      do_reset();
      send(16'h1111, 5'd16);
      send(16'h0222, 5'd12);
      vlc_code = {1'b1, 5'd4, 16'h000F};
      vlc_valid = 1'b1;
      flush_req = 1'b1;
      chk("t6_ready", vlc_ready, 1);
      step();
      vlc_valid = 1'b0;
      flush_req = 1'b0;
      chk("t6_wait", out_valid, 0);
      step();
      chk("t6_valid", out_valid, 1);
      chk("t6_data", out_data, 32'h1111_222F);
      chk("t6_last", out_last, 0);
      chk("t6_nbits", out_nbits, 32);
      step();
      chk("t6_done", flush_done, 1);
      chk("t6_drop", out_valid, 0);
      step();
      chk("t6_pulse", flush_done, 0);
      chk("t6_no_partial", out_valid, 0);
      chk("t6_total", total_bits, 32);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/vlc_bit_packer.md
Name: vlc_bit_packer

Overview:
- Parametrised successor of the per-symbol code-length stage in the Huffman encoder path.
- Accepts length-tagged VLC words, extracts and clamps the length field, and packs the variable-length codes MSB-first into fixed OUT_W-bit words.
- Uses valid/ready handshakes on both sides and supports an explicit flush that zero-pads the final partial word.
- Sits between the Huffman code-table lookup and the output stream writer.

Parameters:
- CODE_W, 16: maximum code bits per symbol; code is right-aligned in the input word.
- LEN_W, 5: width of the length field.
- OUT_W, 32: packed output word width; must be >= CODE_W.
- CNT_W, 32: width of the total-bit counter.

Ports:
- clk  in  1  clock.
- rstN  in  1  synchronous active-low reset.
- vlc_code  in  CODE_W+LEN_W+1  input word. Fields:
  - [CODE_W-1:0]: code.
  - [CODE_W+LEN_W-1:CODE_W]: length.
  - MSB: reserved, ignored.
- vlc_valid  in  1  input word valid.
- vlc_ready  out  1  block can accept an input word.
- flush_req  in  1  single-cycle pulse requesting a flush.
- out_data  out  OUT_W  packed word; first code bit is at the MSB.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts the word.
- out_last  out  1  marks the final word of a flush.
- out_nbits  out  $clog2(OUT_W)+1  meaningful bits in out_data.
- code_length  out  LEN_W  raw length field of the last accepted word.
- len_err  out  1  sticky flag: a length > CODE_W was received.
- flush_done  out  1  one-cycle pulse when a flush completes.
- total_bits  out  CNT_W  running count of packed bits; wraps modulo 2^CNT_W.

Behaviour:
- Reset: rstN is sampled only on the clk edge. On reset:
  - Every output is 0, including the registered vlc_ready.
  - The accumulator and bit_cnt are cleared; partial bits are discarded.
  - The state machine returns to RUN.
- Storage:
  - Accumulator is ACC_W = OUT_W + CODE_W bits, left-aligned.
  - bit_cnt (0..ACC_W) is the number of bits held.
- Input handshake:
  - Fire = vlc_valid && vlc_ready.
  - vlc_ready = (state == RUN) && (bit_cnt <= OUT_W), evaluated on the current-cycle register values.
- On fire:
  - len_eff = min(length, CODE_W). A length > CODE_W sets len_err until the next reset.
  - Append the low len_eff bits of the code directly below the existing bits; upper code bits are masked.
  - code_length <= raw length field; total_bits += len_eff.
  - A length of 0 is accepted, adds no bits, and still updates code_length.
- Output register load:
  - Condition: bit_cnt >= OUT_W and (!out_valid || out_ready).
  - out_data <= top OUT_W accumulator bits, out_nbits <= OUT_W, out_last <= 0, out_valid <= 1.
  - The accumulator shifts left by OUT_W.
- Same-cycle pop and append: pop is applied first, then append, so new bit_cnt = bit_cnt - OUT_W + len_eff.
- Latency: a full word is presented on out_valid in the cycle after bit_cnt reaches OUT_W, provided the output register is free.
- When out_valid && out_ready and no new load occurs, out_valid <= 0.
- State machine: RUN, FLUSH, LAST.
  - RUN -> FLUSH on flush_req. If flush_req coincides with an input fire, that word is packed before the flush.
  - FLUSH: no input is accepted; full words drain normally. Once bit_cnt < OUT_W and the output register is free:
    - If bit_cnt > 0: load the zero-padded partial word with out_last=1 and out_nbits=bit_cnt, clear bit_cnt, go to LAST.
    - If bit_cnt == 0: pulse flush_done, go to RUN.
  - LAST: on the out_ready handshake of the last word, pulse flush_done on the next cycle, then go to RUN.
- flush_req is ignored while in FLUSH or LAST.
- out_data, out_last and out_nbits hold stable while out_valid && !out_ready.

Decomposition:
- Package vlc_pkg holds:
  - Default widths CODE_W, LEN_W, OUT_W.
  - Field-offset constants LEN_LSB = CODE_W and LEN_MSB = CODE_W + LEN_W - 1.
  - ACC_W.
  - State enum {RUN, FLUSH, LAST}.
- Sub-module vlc_field_split (combinational) performs:
  - Length and code extraction.
  - Clamp to CODE_W and the code mask.
  - len_err detection.
- The packer core (accumulator, state machine, handshakes) stays in vlc_bit_packer.

Test Plan:
1. Send codes 0xABCD (len 16) then 0x1234 (len 16), out_ready=1 -> out_data=0x ABCD1234, out_nbits=32, out_last=0, one cycle after the second accept; total_bits=32.
2. Send 3'b101 (len 3) and 5'b10011 (len 5), then flush_req -> out_data=0xB3000000, out_last=1, out_nbits=8; flush_done pulses one cycle after the handshake.
3. Hold out_ready=0 and stream 0xAAAA, 0xBBBB, 0xCCCC, 0xDDDD, 0xEEEE (len 16 each) -> out_data=0xAAAABBBB held stable and vlc_ready=0 after 0xEEEE. Then release out_ready -> 0xCCCCDDDD follows in order; 0xEEEE remains buffered (bit_cnt=16).
4. Send length 20 with code 0x00FF -> len_err=1, code_length=20, exactly 16 bits (0x00FF) packed, total_bits += 16. Then send a length-0 word -> bit_cnt unchanged.
5. After 24 bits are buffered, hold rstN=0 for one clock -> all outputs 0. A following flush_req produces no out_valid and flush_done one cycle later.
6. Assert flush_req in the same cycle as an input fire of 0xF (len 4) with 28 bits already buffered -> one full word with out_last=0, then flush_done with no partial word (bit_cnt=0).
